// File: rtl/spi_burst_master.sv
`timescale 1ns/1ps
// SPI burst master: per-burst CPOL/CPHA, multi-word bursts under one chip select, abort.
// Next word is pulled on tx_ack with no gap; the source gets 2*DATA_W*DIV cycles to present it.
module spi_burst_master #(
  parameter int DATA_W = 8,
  parameter int DIV    = 13,
  parameter int NUM_SS = 1,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [NUM_SS-1:0] ss_mask,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_ack,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [NUM_SS-1:0] ss_n,
  output logic [DATA_W-1:0] data_out,
  output logic              new_data,
  output logic              busy
);

  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0]  DIV_M1    = CNT_W'(DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  hp_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [LEN_W-1:0]  word_cnt;
  logic [LEN_W-1:0]  len_q;
  logic              cpol_q;
  logic              cpha_q;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_src;
  logic              pend_done;
  logic              pend_load;
  logic              load_now;
  logic              leading;
  logic              last_edge;

  // With DIV=1 the reload and the next leading edge share a cycle, so shifts read tx_src.
  always_comb begin
    load_now  = pend_load && !abort;
    tx_src    = load_now ? data_in : tx_sh;
    leading   = !edge_cnt[0];
    last_edge = (edge_cnt == EDGE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hp_cnt    <= '0;
      edge_cnt  <= '0;
      word_cnt  <= '0;
      len_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      pend_done <= 1'b0;
      pend_load <= 1'b0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      ss_n      <= '1;
      busy      <= 1'b0;
      tx_ack    <= 1'b0;
      new_data  <= 1'b0;
      data_out  <= '0;
    end else begin
      new_data  <= 1'b0;
      tx_ack    <= 1'b0;
      pend_done <= 1'b0;
      pend_load <= 1'b0;
      if (pend_done) begin
        data_out <= rx_sh;
        new_data <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            len_q    <= len;
            ss_n     <= ~ss_mask;
            busy     <= 1'b1;
            sck      <= cpol;
            word_cnt <= '0;
            hp_cnt   <= '0;
            edge_cnt <= '0;
            if (cpha) begin
              tx_sh <= data_in;
            end else begin
              tx_sh <= {data_in[DATA_W-2:0], 1'b0};
              mosi  <= data_in[DATA_W-1];
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (abort) begin
            state  <= HOLD;
            hp_cnt <= '0;
            sck    <= cpol_q;
          end else if (hp_cnt == DIV_M1) begin
            hp_cnt <= '0;
            state  <= SHIFT;
          end else begin
            hp_cnt <= hp_cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (abort) begin
            state  <= HOLD;
            hp_cnt <= '0;
            sck    <= cpol_q;
          end else begin
            if (load_now) begin
              tx_ack   <= 1'b1;
              word_cnt <= word_cnt + LEN_W'(1);
              if (cpha_q) begin
                tx_sh <= data_in;
              end else begin
                tx_sh <= {data_in[DATA_W-2:0], 1'b0};
                mosi  <= data_in[DATA_W-1];
              end
            end
            if (hp_cnt == DIV_M1) begin
              hp_cnt   <= '0;
              sck      <= ~sck;
              edge_cnt <= edge_cnt + EDGE_W'(1);
              if (leading ^ cpha_q) begin
                rx_sh <= {rx_sh[DATA_W-2:0], miso};
              end else if (cpha_q || !last_edge) begin
                mosi  <= tx_src[DATA_W-1];
                tx_sh <= {tx_src[DATA_W-2:0], 1'b0};
              end
              if (last_edge) begin
                edge_cnt  <= '0;
                pend_done <= 1'b1;
                if (word_cnt == len_q) state <= HOLD;
                else pend_load <= 1'b1;
              end
            end else begin
              hp_cnt <= hp_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          sck <= cpol_q;
          if (hp_cnt == DIV_M1) begin
            hp_cnt <= '0;
            ss_n   <= '1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            hp_cnt <= hp_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_master.sv
`timescale 1ns/1ps
// Directed bench for spi_burst_master: scoreboard of expected received words plus per-burst timing counts.
module tb_spi_burst_master;
  localparam int DATA_W = 8;
  localparam int DIV    = 2;
  localparam int NUM_SS = 3;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic [NUM_SS-1:0] ss_mask = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              miso;
  logic              tx_ack, mosi, sck, new_data, busy;
  logic [NUM_SS-1:0] ss_n;
  logic [DATA_W-1:0] data_out;

  spi_burst_master #(.DATA_W(DATA_W), .DIV(DIV), .NUM_SS(NUM_SS), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cpol(cpol), .cpha(cpha),
    .ss_mask(ss_mask), .len(len), .data_in(data_in), .tx_ack(tx_ack), .miso(miso),
    .mosi(mosi), .sck(sck), .ss_n(ss_n), .data_out(data_out), .new_data(new_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_mem [0:511];
  int exp_wr = 0;
  int exp_rd = 0;
  logic [7:0] tx_words [0:255];
  int feed_idx = 0;
  int busy_cyc = 0, ss_bad = 0, nd_cnt = 0, ack_cnt = 0, sck_edges = 0, samp_edges = 0;
  int b0, n0, a0, s0, e0;
  logic [31:0] mosi_rec = '0;
  logic cur_pol = 1'b0, cur_pha = 1'b0, loop = 1'b0;
  logic [NUM_SS-1:0] exp_mask = '0;
  logic [63:0] slv_stream = '0;
  int edge_base = 0;
  int miso_idx;

  // Slave model: loopback, or a bit stream advanced after each master sampling edge.
  always_comb begin
    miso_idx = samp_edges - edge_base;
    if (loop) miso = mosi;
    else if (miso_idx >= 0 && miso_idx < 64) miso = slv_stream[63 - miso_idx];
    else miso = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    exp_mem[exp_wr] = w;
    exp_wr++;
  endtask

  task automatic monitor();
    logic ps, pb;
    ps = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_cyc++;
        if (ss_n !== ~exp_mask) ss_bad++;
      end
      if (pb && busy === 1'b1 && sck !== ps) begin
        sck_edges++;
        if (cur_pha ? (sck == cur_pol) : (sck != cur_pol)) begin
          samp_edges++;
          mosi_rec = {mosi_rec[30:0], mosi};
        end
      end
      if (new_data === 1'b1) begin
        nd_cnt++;
        if (exp_rd == exp_wr) begin
          total++;
          bad++;
          $display("FAIL new_data: unexpected word 0x%0h, none expected", data_out);
        end else begin
          chk("data_out", 32'(data_out), 32'(exp_mem[exp_rd]));
          exp_rd++;
        end
      end
      if (tx_ack === 1'b1) begin
        ack_cnt++;
        feed_idx++;
        if (feed_idx < 255) data_in = tx_words[feed_idx + 1];
      end
      ps = sck;
      pb = (busy === 1'b1);
    end
  endtask

  task automatic launch(input logic pol, input logic pha, input logic [NUM_SS-1:0] mask,
                        input logic [LEN_W-1:0] ln);
    @(negedge clk);
    cur_pol = pol; cur_pha = pha; exp_mask = mask; edge_base = samp_edges; feed_idx = 0;
    b0 = busy_cyc; n0 = nd_cnt; a0 = ack_cnt; s0 = ss_bad; e0 = sck_edges;
    cpol = pol; cpha = pha; ss_mask = mask; len = ln; data_in = tx_words[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_in = tx_words[1];
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL timeout: busy still high after %0d cycles", budget);
    end
    #2;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 256; k++) tx_words[k] = '0;
    fork
      monitor();
    join_none
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_sck", 32'(sck), 32'h0);
    chk("rst_mosi", 32'(mosi), 32'h0);
    chk("rst_ss_n", 32'(ss_n), 32'h7);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tx_ack", 32'(tx_ack), 32'h0);
    chk("rst_new_data", 32'(new_data), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);

    // mode 0, single word, miso looped to mosi
    loop = 1'b1; tx_words[0] = 8'hA5; push(8'hA5); mosi_rec = '0;
    launch(1'b0, 1'b0, 3'b001, 8'd0);
    wait_idle(200);
    chk("m0_busy_cycles", busy_cyc - b0, 36);
    chk("m0_new_data_cnt", nd_cnt - n0, 1);
    chk("m0_tx_ack_cnt", ack_cnt - a0, 0);
    chk("m0_mosi_bits", 32'(mosi_rec[7:0]), 32'hA5);
    chk("m0_sck_edges", sck_edges - e0, 16);
    chk("m0_ss_n_held", ss_bad - s0, 0);
    chk("m0_sck_idle", 32'(sck), 32'h0);
    chk("m0_ss_n_idle", 32'(ss_n), 32'h7);

    // mode 3 three-word burst, with an ignored start mid-burst
    loop = 1'b0; tx_words[0] = 8'h12; tx_words[1] = 8'h34; tx_words[2] = 8'h56;
    slv_stream = {8'hC3, 8'h3C, 8'hFF, 40'h0};
    push(8'hC3); push(8'h3C); push(8'hFF); mosi_rec = '0;
    launch(1'b1, 1'b1, 3'b001, 8'd2);
    chk("m3_setup_sck", 32'(sck), 32'h1);
    repeat (30) @(negedge clk);
    cpol = 1'b0; len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(400);
    chk("m3_busy_cycles", busy_cyc - b0, 100);
    chk("m3_new_data_cnt", nd_cnt - n0, 3);
    chk("m3_tx_ack_cnt", ack_cnt - a0, 2);
    chk("m3_mosi_bits", 32'(mosi_rec[23:0]), 32'h123456);
    chk("m3_ss_n_held", ss_bad - s0, 0);
    chk("m3_sck_idle", 32'(sck), 32'h1);
    chk("m3_sb_drained", exp_wr - exp_rd, 0);

    // abort at the 5th SCK edge of word 1
    loop = 1'b1; tx_words[0] = 8'h11; tx_words[1] = 8'h22; tx_words[2] = 8'h33; push(8'h11);
    launch(1'b0, 1'b0, 3'b001, 8'd2);
    n = 0;
    while (sck_edges - e0 < 21 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ab_reach_edge21", sck_edges - e0, 21);
    abort = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      abort = 1'b0;
      n++;
    end while (ss_n !== 3'b111 && n < 20);
    chk("ab_ss_release_cycles", n, DIV + 1);
    chk("ab_busy_low", 32'(busy), 32'h0);
    chk("ab_sck_idle", 32'(sck), 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("ab_new_data_cnt", nd_cnt - n0, 1);
    chk("ab_tx_ack_cnt", ack_cnt - a0, 1);
    chk("ab_data_out", 32'(data_out), 32'h11);
    chk("ab_sb_drained", exp_wr - exp_rd, 0);

    // asynchronous reset mid-SHIFT, with sck and mosi high at that moment
    tx_words[0] = 8'h77;
    launch(1'b0, 1'b0, 3'b001, 8'd0);
    repeat (16) @(negedge clk);
    #1;
    chk("ar_pre_sck", 32'(sck), 32'h1);
    rst = 1'b1;
    #1;
    chk("ar_ss_n", 32'(ss_n), 32'h7);
    chk("ar_sck", 32'(sck), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_mosi", 32'(mosi), 32'h0);
    chk("ar_data_out", 32'(data_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // mode 1 on chip select 1 only
    loop = 1'b0; tx_words[0] = 8'h3C; slv_stream = {8'h96, 56'h0}; push(8'h96); mosi_rec = '0;
    launch(1'b0, 1'b1, 3'b010, 8'd0);
    wait_idle(200);
    chk("m1_busy_cycles", busy_cyc - b0, 36);
    chk("m1_new_data_cnt", nd_cnt - n0, 1);
    chk("m1_mosi_bits", 32'(mosi_rec[7:0]), 32'h3C);
    chk("m1_ss_n_only1", ss_bad - s0, 0);
    chk("m1_ss_n_idle", 32'(ss_n), 32'h7);

    // mode 2 with no chip select
    tx_words[0] = 8'hE1; slv_stream = {8'h5B, 56'h0}; push(8'h5B); mosi_rec = '0;
    launch(1'b1, 1'b0, 3'b000, 8'd0);
    wait_idle(200);
    chk("m2_busy_cycles", busy_cyc - b0, 36);
    chk("m2_new_data_cnt", nd_cnt - n0, 1);
    chk("m2_mosi_bits", 32'(mosi_rec[7:0]), 32'hE1);
    chk("m2_ss_n_none", ss_bad - s0, 0);
    chk("m2_sck_idle", 32'(sck), 32'h1);

    // maximum burst length, looped back
    loop = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tx_words[k] = 8'(k * 37 + 11);
      push(8'(k * 37 + 11));
    end
    launch(1'b0, 1'b0, 3'b001, 8'd255);
    wait_idle(9000);
    chk("max_busy_cycles", busy_cyc - b0, 8196);
    chk("max_new_data_cnt", nd_cnt - n0, 256);
    chk("max_tx_ack_cnt", ack_cnt - a0, 255);
    chk("max_sb_drained", exp_wr - exp_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
